// File: rtl/time_set_ctrl.sv
// Time-setting controller for a clock display.
// The mode button steps RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
// In a SET state, up/down edges produce one-cycle inc/dec strobes, and a
// held button auto-repeats. An idle timeout returns to RUN, and a blink
// signal flags the field being edited.
module time_set_ctrl #(
    parameter int HOLD_TICKS    = 50,
    parameter int REPEAT_TICKS  = 10,
    parameter int TIMEOUT_TICKS = 1000,
    parameter int BLINK_TICKS   = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       run_en,
    output logic       adjust,
    output logic [1:0] field_sel,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       blink
);

    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam int BW = $clog2(BLINK_TICKS + 1);

    // The state encoding doubles as the field_sel code.
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        SET_SEC  = 2'b11
    } state_t;

    state_t        state_reg, state_next;
    logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
    logic [RW-1:0] rep_cnt_reg, rep_cnt_next;
    logic [TW-1:0] to_cnt_reg, to_cnt_next;
    logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
    logic          blink_reg, blink_next;
    logic          inc_reg, inc_next;
    logic          dec_reg, dec_next;

    // Bit 2 = mode, bit 1 = up, bit 0 = down.
    logic [2:0] btn;
    logic [2:0] prev_reg;
    logic [2:0] edge_det;

    logic mode_edge, up_edge, down_edge;
    logic in_set, one_held, state_change, hold_fire, pulse_next;

    assign btn       = {btn_mode, btn_up, btn_down};
    assign mode_edge = edge_det[2];
    assign up_edge   = edge_det[1];
    assign down_edge = edge_det[0];

    // Per-button rising-edge detectors. Previous levels reset high so a
    // button held through reset does not register as a press.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_edge
            always_ff @(posedge clk) begin
                if (rst) prev_reg[gi] <= 1'b1;
                else     prev_reg[gi] <= btn[gi];
            end
            assign edge_det[gi] = btn[gi] & ~prev_reg[gi];
        end
    endgenerate

    assign in_set   = (state_reg != RUN);
    assign one_held = btn_up ^ btn_down;

    // State transitions: a mode edge always advances; otherwise the idle
    // timeout forces RUN from any SET state.
    always_comb begin
        state_next = state_reg;
        if (mode_edge) begin
            case (state_reg)
                RUN:      state_next = SET_HOUR;
                SET_HOUR: state_next = SET_MIN;
                SET_MIN:  state_next = SET_SEC;
                default:  state_next = RUN;
            endcase
        end else if (in_set && (to_cnt_reg == TW'(TIMEOUT_TICKS))) begin
            state_next = RUN;
        end
    end

    assign state_change = (state_next != state_reg);

    // Auto-repeat: the hold counter saturates at HOLD_TICKS (first repeat),
    // then the repeat counter fires every REPEAT_TICKS ticks. Any edge,
    // release, both-pressed or state change restarts the sequence.
    always_comb begin
        hold_cnt_next = hold_cnt_reg;
        rep_cnt_next  = rep_cnt_reg;
        hold_fire     = 1'b0;
        if (!in_set || state_change || !one_held || up_edge || down_edge) begin
            hold_cnt_next = '0;
            rep_cnt_next  = '0;
        end else if (tick) begin
            if (hold_cnt_reg != HW'(HOLD_TICKS)) begin
                hold_cnt_next = hold_cnt_reg + 1'b1;
                hold_fire     = (hold_cnt_reg == HW'(HOLD_TICKS - 1));
            end else if (rep_cnt_reg >= RW'(REPEAT_TICKS - 1)) begin
                rep_cnt_next = '0;
                hold_fire    = 1'b1;
            end else begin
                rep_cnt_next = rep_cnt_reg + 1'b1;
            end
        end
    end

    // Pulse selection: a mode change suppresses any pulse; an edge with the
    // opposite button low gives an immediate strobe; otherwise auto-repeat.
    always_comb begin
        inc_next = 1'b0;
        dec_next = 1'b0;
        if (in_set && !state_change) begin
            if (up_edge && !btn_down) begin
                inc_next = 1'b1;
            end else if (down_edge && !btn_up) begin
                dec_next = 1'b1;
            end else if (hold_fire) begin
                inc_next = btn_up & ~btn_down;
                dec_next = btn_down & ~btn_up;
            end
        end
    end

    assign pulse_next = inc_next | dec_next;

    // Idle timeout: counts ticks in SET states, restarted by any activity.
    always_comb begin
        to_cnt_next = to_cnt_reg;
        if (!in_set || state_change || (|edge_det) || pulse_next) begin
            to_cnt_next = '0;
        end else if (tick && (to_cnt_reg != TW'(TIMEOUT_TICKS))) begin
            to_cnt_next = to_cnt_reg + 1'b1;
        end
    end

    // Blink: forced on when entering a SET state or after a pulse, then
    // toggles every BLINK_TICKS ticks; off in RUN.
    always_comb begin
        blink_next     = blink_reg;
        blink_cnt_next = blink_cnt_reg;
        if (state_next == RUN) begin
            blink_next     = 1'b0;
            blink_cnt_next = '0;
        end else if (state_change || pulse_next) begin
            blink_next     = 1'b1;
            blink_cnt_next = '0;
        end else if (tick) begin
            if (blink_cnt_reg >= BW'(BLINK_TICKS - 1)) begin
                blink_next     = ~blink_reg;
                blink_cnt_next = '0;
            end else begin
                blink_cnt_next = blink_cnt_reg + 1'b1;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN;
            hold_cnt_reg  <= '0;
            rep_cnt_reg   <= '0;
            to_cnt_reg    <= '0;
            blink_cnt_reg <= '0;
            blink_reg     <= 1'b0;
            inc_reg       <= 1'b0;
            dec_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hold_cnt_reg  <= hold_cnt_next;
            rep_cnt_reg   <= rep_cnt_next;
            to_cnt_reg    <= to_cnt_next;
            blink_cnt_reg <= blink_cnt_next;
            blink_reg     <= blink_next;
            inc_reg       <= inc_next;
            dec_reg       <= dec_next;
        end
    end

    assign field_sel = state_reg;
    assign run_en    = (state_reg == RUN);
    assign adjust    = ~run_en;
    assign inc_pulse = inc_reg;
    assign dec_pulse = dec_reg;
    assign blink     = blink_reg;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: the stimulus pushes each expected
// pulse (cycle, direction, field); a forked monitor pops on every pulse.
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       run_en, adjust, inc_pulse, dec_pulse, blink;
    logic [1:0] field_sel;

    typedef struct {
        int         cyc;
        logic       inc;
        logic       dec;
        logic [1:0] field;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    time_set_ctrl #(
        .HOLD_TICKS(5), .REPEAT_TICKS(2), .TIMEOUT_TICKS(8), .BLINK_TICKS(3)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .run_en(run_en), .adjust(adjust), .field_sel(field_sel),
        .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .blink(blink)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, req);
        end else begin
            $display("[TB] ok   %s: %h", name, act);
        end
    endtask

    // {run_en, adjust, field_sel} for a given field code.
    task automatic check_field(input string name, input logic [1:0] f);
        check(name, {run_en, adjust, field_sel}, {(f == 2'b00), (f != 2'b00), f});
    endtask

    task automatic expect_pulse(input logic inc, input logic dec, input logic [1:0] f);
        exp_t e;
        e.cyc = cyc + 1;
        e.inc = inc;
        e.dec = dec;
        e.field = f;
        exp_q.push_back(e);
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        cycle();
        btn_mode = 1'b0;
        cycle();
    endtask

    task automatic give_tick();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        cycle();
    endtask

    // Monitor: every pulse cycle must match the head of the scoreboard.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (inc_pulse || dec_pulse) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_pulse: cyc=%0d inc=%b dec=%b expected no pulse",
                             cyc, inc_pulse, dec_pulse);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.inc !== inc_pulse || e.dec !== dec_pulse ||
                        e.field !== field_sel) begin
                        fails++;
                        $display("[TB] FAIL pulse: got cyc=%0d inc=%b dec=%b field=%b expected cyc=%0d inc=%b dec=%b field=%b",
                                 cyc, inc_pulse, dec_pulse, field_sel, e.cyc, e.inc, e.dec, e.field);
                    end else begin
                        $display("[TB] ok   pulse: cyc=%0d inc=%b dec=%b field=%b",
                                 cyc, inc_pulse, dec_pulse, field_sel);
                    end
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset with mode and up held: outputs idle, and no edge on release.
        btn_mode = 1'b1;
        btn_up   = 1'b1;
        cycle(); cycle(); cycle();
        check_field("reset_state", 2'b00);
        check("reset_outs", {1'b0, inc_pulse, dec_pulse, blink}, 4'h0);
        rst = 1'b0;
        cycle(); cycle(); cycle();
        check_field("mode_held_through_reset", 2'b00);
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        cycle();

        // Four mode presses walk through every field and back to RUN.
        press_mode(); check_field("mode1_hour", 2'b01);
        check("blink_on_entry", {3'b0, blink}, 4'h1);
        press_mode(); check_field("mode2_min", 2'b10);
        press_mode(); check_field("mode3_sec", 2'b11);
        press_mode(); check_field("mode4_run", 2'b00);
        check("blink_run", {3'b0, blink}, 4'h0);

        // SET_MIN: a single up edge gives one inc_pulse one cycle later.
        press_mode(); press_mode();
        btn_up = 1'b1;
        expect_pulse(1'b1, 1'b0, 2'b10);
        cycle(); cycle(); cycle();
        btn_up = 1'b0;
        cycle();
        check_field("single_up_field", 2'b10);

        // SET_HOUR: down held; pulses at the edge and ticks 5, 7, 9.
        // Released on the cycle of the 11th tick, so that tick adds nothing.
        press_mode(); press_mode(); press_mode();
        check_field("hold_entry_hour", 2'b01);
        btn_down = 1'b1;
        expect_pulse(1'b0, 1'b1, 2'b01);
        cycle(); cycle();
        for (int t = 1; t <= 10; t++) begin
            tick = 1'b1;
            if (t == 5 || t == 7 || t == 9) expect_pulse(1'b0, 1'b1, 2'b01);
            cycle();
            tick = 1'b0;
            cycle();
        end
        btn_down = 1'b0;
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        cycle(); cycle();
        check_field("hold_still_hour", 2'b01);

        // SET_SEC: up and down together are no press, even when held.
        press_mode(); press_mode();
        check_field("both_entry_sec", 2'b11);
        btn_up = 1'b1;
        btn_down = 1'b1;
        cycle();
        for (int t = 0; t < 4; t++) give_tick();
        btn_up = 1'b0;
        btn_down = 1'b0;
        cycle();
        // Mode and up edges together: mode wins, no pulse.
        btn_mode = 1'b1;
        btn_up = 1'b1;
        cycle();
        btn_mode = 1'b0;
        cycle();
        btn_up = 1'b0;
        cycle(); cycle();
        check_field("mode_beats_up", 2'b00);

        // Timeout: 7 idle ticks stay in SET_HOUR; a press restarts the count.
        press_mode();
        for (int t = 1; t <= 7; t++) begin
            give_tick();
            if (t == 3) check("blink_toggle_off", {3'b0, blink}, 4'h0);
        end
        check_field("timeout_7_ticks", 2'b01);
        btn_up = 1'b1;
        expect_pulse(1'b1, 1'b0, 2'b01);
        cycle();
        btn_up = 1'b0;
        cycle();
        for (int t = 1; t <= 7; t++) give_tick();
        check_field("timeout_restarted", 2'b01);
        give_tick();
        cycle();
        check_field("timeout_to_run", 2'b00);

        // Reset during auto-repeat: the tick-7 repeat is dropped.
        press_mode();
        btn_up = 1'b1;
        expect_pulse(1'b1, 1'b0, 2'b01);
        cycle(); cycle();
        for (int t = 1; t <= 6; t++) begin
            tick = 1'b1;
            if (t == 5) expect_pulse(1'b1, 1'b0, 2'b01);
            cycle();
            tick = 1'b0;
            cycle();
        end
        tick = 1'b1;
        rst = 1'b1;
        cycle();
        tick = 1'b0;
        cycle();
        check_field("rst_mid_repeat", 2'b00);
        check("rst_mid_repeat_outs", {1'b0, inc_pulse, dec_pulse, blink}, 4'h0);
        rst = 1'b0;
        cycle();
        for (int t = 0; t < 3; t++) give_tick();
        check_field("after_rst_run", 2'b00);
        btn_up = 1'b0;
        cycle(); cycle();

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL missing_pulses: got %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter HOLD_TICKS, default 50: ticks a lone up/down must be held before the first auto-repeat pulse.
REQ-002 SHALL have parameter REPEAT_TICKS, default 10: ticks between successive auto-repeat pulses.
REQ-003 SHALL have parameter TIMEOUT_TICKS, default 1000: ticks without a button edge or repeat pulse before the block forces RUN.
REQ-004 SHALL have parameter BLINK_TICKS, default 25: ticks per blink half-period.
REQ-005 SHALL have port clk  in  1  sole clock, all logic on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port tick  in  1  one-cycle timing-base pulse.
REQ-008 SHALL have port btn_mode  in  1  mode button, debounced level.
REQ-009 SHALL have port btn_up  in  1  up button, debounced level.
REQ-010 SHALL have port btn_down  in  1  down button, debounced level.
REQ-011 SHALL have port run_en  out  1  count enable for the time counters, high only in RUN.
REQ-012 SHALL have port adjust  out  1  always the inverse of run_en.
REQ-013 SHALL have port field_sel  out  2  field being set: 00 none, 01 hour, 10 minute, 11 second.
REQ-014 SHALL have port inc_pulse  out  1  one-cycle increment strobe to the selected field.
REQ-015 SHALL have port dec_pulse  out  1  one-cycle decrement strobe to the selected field.
REQ-016 SHALL have port blink  out  1  display blink for the selected field, 0 in RUN.

Function
REQ-017 SHALL detect a rising edge per button as current level high and previous-cycle level low.
REQ-018 SHALL implement FSM states RUN, SET_HOUR, SET_MIN and SET_SEC, with field_sel 00/01/10/11 respectively.
REQ-019 SHALL step on each btn_mode edge: RUN to SET_HOUR to SET_MIN to SET_SEC to RUN.
REQ-020 SHALL, in any SET state, return to RUN when the timeout counter reaches TIMEOUT_TICKS.
REQ-021 SHALL increment the timeout counter only on tick, and clear it on any button edge, any inc/dec pulse, and any state change.
REQ-022 SHALL, on a btn_up edge in a SET state with btn_down low, assert inc_pulse for exactly the next cycle; btn_down mirrors this with dec_pulse.
REQ-023 SHALL never assert inc_pulse and dec_pulse in the same cycle.
REQ-024 SHALL treat btn_up and btn_down high together as no press: no pulses, hold counter cleared.
REQ-025 SHALL, when a btn_mode edge coincides with an up/down edge, let mode win: state advances, no pulse.
REQ-026 SHALL, in RUN, ignore up/down entirely and keep both pulse outputs low.
REQ-027 SHALL run a hold counter on tick while exactly one of btn_up/btn_down is held in a SET state.
REQ-028 SHALL emit one pulse of the held direction when the hold counter reaches HOLD_TICKS, then one every REPEAT_TICKS ticks after that.
REQ-029 SHALL clear the hold counter and stop repeating on release or state change.
REQ-030 SHALL register all pulses so each is high for exactly one clk cycle, one cycle after the causing edge or tick.
REQ-031 SHALL force blink to 1 on entry to a SET state and after every inc/dec pulse, restarting the blink counter.
REQ-032 SHALL otherwise toggle blink every BLINK_TICKS ticks in SET states.
REQ-033 SHALL size every counter to hold its largest parameter value and saturate it, never wrap.

Reset
REQ-034 SHALL, while rst is high at a clk edge, set state RUN, run_en=1, adjust=0, field_sel=00, inc_pulse=0, dec_pulse=0, blink=0, and clear all counters.
REQ-035 SHALL reset the previous-level registers to 1, so a button held through reset produces no edge.
REQ-036 SHALL let rst asserted mid-repeat or mid-SET drop any pending pulse and force RUN on the next edge.

Verification
REQ-037 SHALL cover: 4 btn_mode presses from reset -> field_sel 01, 10, 11, 00; run_en low only during the first three.
REQ-038 SHALL cover: SET_MIN, single btn_up edge -> exactly one inc_pulse, one cycle after the edge, dec_pulse stays 0.
REQ-039 SHALL cover: HOLD_TICKS=5, REPEAT_TICKS=2, btn_down held 11 ticks in SET_HOUR -> 4 dec_pulses: edge, tick 5, tick 7, tick 9.
REQ-040 SHALL cover: btn_up and btn_down together in SET_SEC -> no pulses; btn_mode edge with btn_up edge -> state RUN, no pulse.
REQ-041 SHALL cover: TIMEOUT_TICKS=8 in SET_HOUR with no input -> RUN after the 8th tick; any press at tick 7 restarts the count.
REQ-042 SHALL cover: btn_up held through rst release -> no inc_pulse; rst during auto-repeat -> RUN with all pulses 0.
